// File: rtl/hazard_pkg.sv
// Shared constants and helpers for the decode-stage hazard/stall controller.
package hazard_pkg;

  localparam int unsigned DEF_REG_ADDR_W = 4;
  localparam int unsigned DEF_CNT_W      = 16;

  // Width of the load-use window counter for a given memory latency.
  function automatic int unsigned win_cnt_w(input int unsigned mem_lat);
    return $clog2(mem_lat + 1);
  endfunction

endpackage

// File: rtl/hazard_src_compare.sv
// Compares one decode source index against the EX and MEM destinations.
module hazard_src_compare
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] i_Src,
  input  logic                  i_Src_Valid,
  input  logic                  i_Exe_Wb_En,
  input  logic [REG_ADDR_W-1:0] i_Exe_Dst,
  input  logic                  i_Mem_Wb_En,
  input  logic [REG_ADDR_W-1:0] i_Mem_Dst,
  output logic                  o_Exe_Hit,
  output logic                  o_Mem_Hit
);

  // Register 0 is an ordinary register, so no zero-index exemption.
  assign o_Exe_Hit = i_Src_Valid & i_Exe_Wb_En & (i_Src == i_Exe_Dst);
  assign o_Mem_Hit = i_Src_Valid & i_Mem_Wb_En & (i_Src == i_Mem_Dst);

endmodule

// File: rtl/hazard_stall_controller.sv
// Decode-stage hazard detector with load-use stall window and stall statistics.
module hazard_stall_controller
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int unsigned NUM_SRC    = 3,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] i_Src,
  input  logic [NUM_SRC-1:0]            i_Src_Valid,
  input  logic                          i_Sig_Exe_Write_Back_Enable,
  input  logic [REG_ADDR_W-1:0]         i_Exe_Destination,
  input  logic                          i_Sig_Exe_Memory_Read_Enable,
  input  logic                          i_Sig_Memory_Write_Back_Enable,
  input  logic [REG_ADDR_W-1:0]         i_Memory_Destination,
  input  logic                          i_Sig_Forward_Enable,
  input  logic                          i_Flush,
  output logic                          o_Sig_Hazard_Detected,
  output logic [NUM_SRC-1:0]            o_Hazard_Src,
  output logic                          o_Stall_Window,
  output logic [CNT_W-1:0]              o_Stall_Count
);

  localparam int unsigned     WIN_W    = win_cnt_w(MEM_LAT);
  localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(MEM_LAT - 1);

  logic [NUM_SRC-1:0] w_exe_hit;
  logic [NUM_SRC-1:0] w_mem_hit;
  logic [NUM_SRC-1:0] w_mask;
  logic               w_raw;
  logic               w_win_active;
  logic               w_stall;
  logic [WIN_W-1:0]   w_win_nxt;
  logic [WIN_W-1:0]   r_win_cnt;
  logic [CNT_W-1:0]   r_stall_cnt;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    hazard_src_compare #(
      .REG_ADDR_W (REG_ADDR_W)
    ) u_cmp (
      .i_Src       (i_Src[k*REG_ADDR_W +: REG_ADDR_W]),
      .i_Src_Valid (i_Src_Valid[k]),
      .i_Exe_Wb_En (i_Sig_Exe_Write_Back_Enable),
      .i_Exe_Dst   (i_Exe_Destination),
      .i_Mem_Wb_En (i_Sig_Memory_Write_Back_Enable),
      .i_Mem_Dst   (i_Memory_Destination),
      .o_Exe_Hit   (w_exe_hit[k]),
      .o_Mem_Hit   (w_mem_hit[k])
    );
  end

  // With forwarding only a load in EX can still cause a stall.
  always_comb begin
    w_mask = w_exe_hit | w_mem_hit;
    if (i_Sig_Forward_Enable) begin
      w_mask = w_exe_hit & {NUM_SRC{i_Sig_Exe_Memory_Read_Enable}};
    end
  end

  assign w_raw        = |w_mask;
  assign w_win_active = (r_win_cnt != '0);
  assign w_stall      = (w_raw | w_win_active) & ~i_Flush;

  // Flush beats decrement, decrement beats a new load (re-detection ignored).
  always_comb begin
    w_win_nxt = r_win_cnt;
    if (i_Flush) begin
      w_win_nxt = '0;
    end else if (w_win_active) begin
      w_win_nxt = r_win_cnt - WIN_W'(1);
    end else if (i_Sig_Forward_Enable && w_raw) begin
      w_win_nxt = WIN_LOAD;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_win_cnt <= '0;
    end else begin
      r_win_cnt <= w_win_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign o_Hazard_Src          = w_mask;
  assign o_Sig_Hazard_Detected = w_stall;
  assign o_Stall_Window        = w_win_active;
  assign o_Stall_Count         = r_stall_cnt;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Self-checking bench: three configurations (default, MEM_LAT=3, CNT_W=4) share one stimulus.
module tb_hazard_stall_controller;

  localparam int unsigned RW = 4;
  localparam int unsigned NS = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic [NS*RW-1:0] src;
  logic [NS-1:0]    srcv;
  logic             wbe;
  logic [RW-1:0]    exed;
  logic             ld;
  logic             wbm;
  logic [RW-1:0]    memd;
  logic             fwd;
  logic             flush;

  logic          stall_a, stall_b, stall_c;
  logic [NS-1:0] mask_a, mask_b, mask_c;
  logic          win_a, win_b, win_c;
  logic [15:0]   cnt_a, cnt_b;
  logic [3:0]    cnt_c;

  logic          d_stall [3];
  logic [NS-1:0] d_mask  [3];
  logic          d_win   [3];
  logic [15:0]   d_cnt   [3];

  always_comb begin
    d_stall[0] = stall_a; d_stall[1] = stall_b; d_stall[2] = stall_c;
    d_mask[0]  = mask_a;  d_mask[1]  = mask_b;  d_mask[2]  = mask_c;
    d_win[0]   = win_a;   d_win[1]   = win_b;   d_win[2]   = win_c;
    d_cnt[0]   = cnt_a;   d_cnt[1]   = cnt_b;   d_cnt[2]   = {12'd0, cnt_c};
  end

  hazard_stall_controller #(.REG_ADDR_W(RW), .NUM_SRC(NS), .MEM_LAT(1), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .i_Src(src), .i_Src_Valid(srcv),
    .i_Sig_Exe_Write_Back_Enable(wbe), .i_Exe_Destination(exed),
    .i_Sig_Exe_Memory_Read_Enable(ld), .i_Sig_Memory_Write_Back_Enable(wbm),
    .i_Memory_Destination(memd), .i_Sig_Forward_Enable(fwd), .i_Flush(flush),
    .o_Sig_Hazard_Detected(stall_a), .o_Hazard_Src(mask_a),
    .o_Stall_Window(win_a), .o_Stall_Count(cnt_a));

  hazard_stall_controller #(.REG_ADDR_W(RW), .NUM_SRC(NS), .MEM_LAT(3), .CNT_W(16)) u_lat3 (
    .clk(clk), .reset(reset), .i_Src(src), .i_Src_Valid(srcv),
    .i_Sig_Exe_Write_Back_Enable(wbe), .i_Exe_Destination(exed),
    .i_Sig_Exe_Memory_Read_Enable(ld), .i_Sig_Memory_Write_Back_Enable(wbm),
    .i_Memory_Destination(memd), .i_Sig_Forward_Enable(fwd), .i_Flush(flush),
    .o_Sig_Hazard_Detected(stall_b), .o_Hazard_Src(mask_b),
    .o_Stall_Window(win_b), .o_Stall_Count(cnt_b));

  hazard_stall_controller #(.REG_ADDR_W(RW), .NUM_SRC(NS), .MEM_LAT(1), .CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .i_Src(src), .i_Src_Valid(srcv),
    .i_Sig_Exe_Write_Back_Enable(wbe), .i_Exe_Destination(exed),
    .i_Sig_Exe_Memory_Read_Enable(ld), .i_Sig_Memory_Write_Back_Enable(wbm),
    .i_Memory_Destination(memd), .i_Sig_Forward_Enable(fwd), .i_Flush(flush),
    .o_Sig_Hazard_Detected(stall_c), .o_Hazard_Src(mask_c),
    .o_Stall_Window(win_c), .o_Stall_Count(cnt_c));

  int checks = 0;
  int errors = 0;

  // Reference model: window tracked as the last cycle number still inside it.
  int cyc        = 0;
  int win_end[3] = '{-1, -1, -1};
  int m_cnt[3]   = '{0, 0, 0};
  int lat[3]     = '{1, 3, 1};
  int cmax[3]    = '{65535, 65535, 15};

  function automatic logic [NS-1:0] m_mask(input logic f);
    logic [NS-1:0] m;
    logic [RW-1:0] s;
    m = '0;
    for (int k = 0; k < NS; k++) begin
      s = src[k*RW +: RW];
      if (srcv[k])
        m[k] = (wbe && s == exed && (!f || ld)) || (!f && wbm && s == memd);
    end
    return m;
  endfunction

  function automatic logic m_inwin(input int p);
    return cyc <= win_end[p];
  endfunction

  function automatic logic m_stall(input int p);
    return ((|m_mask(fwd)) || m_inwin(p)) && !flush;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int p = 0; p < 3; p++) begin
        win_end[p] <= -1;
        m_cnt[p]   <= 0;
      end
    end else begin
      for (int p = 0; p < 3; p++) begin
        if (m_stall(p) && m_cnt[p] < cmax[p]) m_cnt[p] <= m_cnt[p] + 1;
        if (flush) win_end[p] <= cyc;
        else if (!m_inwin(p) && fwd && (|m_mask(1'b1))) win_end[p] <= cyc + lat[p] - 1;
      end
      cyc <= cyc + 1;
    end
  end

  task automatic set_idle();
    src = '0; srcv = '0; wbe = 1'b0; exed = '0; ld = 1'b0;
    wbm = 1'b0; memd = '0; fwd = 1'b0; flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    for (int p = 0; p < 3; p++) begin
      checks++;
      if (d_cnt[p] !== 16'd0 || d_win[p] !== 1'b0 || d_stall[p] !== 1'b0) begin
        errors++;
        $display("FAIL reset inst%0d: cnt=%0d win=%b stall=%b, expected 0/0/0", p, d_cnt[p], d_win[p], d_stall[p]);
      end
    end
  endtask

  task automatic test_no_hazard();
    do_reset();
    src = {4'd5, 4'd4, 4'd3}; srcv = 3'b111; exed = 4'd2; wbe = 1'b1; memd = 4'd1; wbm = 1'b1;
    #1;
    checks++;
    if (stall_a !== 1'b0 || mask_a !== 3'b000) begin
      errors++;
      $display("FAIL no_hazard: stall=%b mask=%b, expected 0/000", stall_a, mask_a);
    end
    tick();
    checks++;
    if (cnt_a !== 16'd0) begin
      errors++;
      $display("FAIL no_hazard_count: got %0d expected 0", cnt_a);
    end
  endtask

  task automatic test_nofwd_mem();
    do_reset();
    src = {4'd5, 4'd1, 4'd3}; srcv = 3'b111; exed = 4'd2; wbe = 1'b1; memd = 4'd1; wbm = 1'b1;
    #1;
    checks++;
    if (stall_a !== 1'b1 || mask_a !== 3'b010) begin
      errors++;
      $display("FAIL nofwd_mem: stall=%b mask=%b, expected 1/010", stall_a, mask_a);
    end
    tick();
    checks++;
    if (cnt_a !== 16'd1) begin
      errors++;
      $display("FAIL nofwd_mem_count: got %0d expected 1", cnt_a);
    end
    wbm = 1'b0;
    #1;
    checks++;
    if (stall_a !== 1'b0) begin
      errors++;
      $display("FAIL nofwd_mem_clear: stall=%b expected 0", stall_a);
    end
  endtask

  task automatic test_fwd_alu();
    do_reset();
    src = {4'd8, 4'd7, 4'd2}; srcv = 3'b111; exed = 4'd2; wbe = 1'b1; fwd = 1'b1; ld = 1'b0;
    #1;
    checks++;
    if (stall_a !== 1'b0 || mask_a !== 3'b000) begin
      errors++;
      $display("FAIL fwd_alu: stall=%b mask=%b, expected 0/000", stall_a, mask_a);
    end
    ld = 1'b1;
    #1;
    checks++;
    if (stall_a !== 1'b1 || mask_a !== 3'b001) begin
      errors++;
      $display("FAIL fwd_load: stall=%b mask=%b, expected 1/001", stall_a, mask_a);
    end
  endtask

  task automatic test_load_use_lat3();
    do_reset();
    src = {4'd0, 4'd0, 4'd2}; srcv = 3'b001; exed = 4'd2; wbe = 1'b1; ld = 1'b1; fwd = 1'b1;
    #1;
    checks++;
    if (stall_b !== 1'b1 || win_b !== 1'b0) begin
      errors++;
      $display("FAIL lu_c1: stall=%b win=%b, expected 1/0", stall_b, win_b);
    end
    tick();
    wbe = 1'b0; ld = 1'b0;
    #1;
    checks++;
    if (stall_b !== 1'b1 || win_b !== 1'b1 || stall_a !== 1'b0 || win_a !== 1'b0) begin
      errors++;
      $display("FAIL lu_c2: lat3 stall=%b win=%b lat1 stall=%b win=%b, expected 1/1 0/0", stall_b, win_b, stall_a, win_a);
    end
    tick();
    fwd = 1'b0;
    #1;
    checks++;
    if (stall_b !== 1'b1 || win_b !== 1'b1) begin
      errors++;
      $display("FAIL lu_c3_fwd_toggle: stall=%b win=%b, expected 1/1", stall_b, win_b);
    end
    tick();
    #1;
    checks++;
    if (stall_b !== 1'b0 || win_b !== 1'b0 || cnt_b !== 16'd3 || cnt_a !== 16'd1) begin
      errors++;
      $display("FAIL lu_end: stall=%b win=%b cnt3=%0d cnt1=%0d, expected 0/0/3/1", stall_b, win_b, cnt_b, cnt_a);
    end
  endtask

  task automatic test_flush_and_reset();
    do_reset();
    src = {4'd0, 4'd0, 4'd2}; srcv = 3'b001; exed = 4'd2; wbe = 1'b1; ld = 1'b1; fwd = 1'b1;
    tick();
    wbe = 1'b0; ld = 1'b0; flush = 1'b1;
    #1;
    checks++;
    if (stall_b !== 1'b0 || win_b !== 1'b1) begin
      errors++;
      $display("FAIL flush_c2: stall=%b win=%b, expected 0/1", stall_b, win_b);
    end
    tick();
    flush = 1'b0;
    #1;
    checks++;
    if (stall_b !== 1'b0 || win_b !== 1'b0 || cnt_b !== 16'd1) begin
      errors++;
      $display("FAIL flush_c3: stall=%b win=%b cnt=%0d, expected 0/0/1", stall_b, win_b, cnt_b);
    end
    wbe = 1'b1; ld = 1'b1;
    tick();
    wbe = 1'b0; ld = 1'b0;
    #1;
    checks++;
    if (win_b !== 1'b1 || cnt_b !== 16'd2) begin
      errors++;
      $display("FAIL rewin: win=%b cnt=%0d, expected 1/2", win_b, cnt_b);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (win_b !== 1'b0 || cnt_b !== 16'd0 || stall_b !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: win=%b cnt=%0d stall=%b, expected 0/0/0", win_b, cnt_b, stall_b);
    end
    @(negedge clk);
    reset = 1'b1;
    wbe = 1'b1; ld = 1'b1; flush = 1'b1;
    #1;
    checks++;
    if (stall_b !== 1'b0) begin
      errors++;
      $display("FAIL flush_hazard: stall=%b expected 0", stall_b);
    end
    tick();
    flush = 1'b0; wbe = 1'b0; ld = 1'b0;
    #1;
    checks++;
    if (win_b !== 1'b0 || stall_b !== 1'b0) begin
      errors++;
      $display("FAIL flush_noload: win=%b stall=%b, expected 0/0", win_b, stall_b);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    src = {4'd0, 4'd0, 4'd1}; srcv = 3'b001; memd = 4'd1; wbm = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      checks++;
      if (stall_c !== 1'b1) begin
        errors++;
        $display("FAIL sat_stall cycle %0d: got %b expected 1", i, stall_c);
      end
      tick();
    end
    checks++;
    if (cnt_c !== 4'd15 || cnt_a !== 16'd20) begin
      errors++;
      $display("FAIL sat_count: cnt4=%0d cnt16=%0d, expected 15/20", cnt_c, cnt_a);
    end
    tick();
    checks++;
    if (cnt_c !== 4'd15) begin
      errors++;
      $display("FAIL sat_hold: got %0d expected 15", cnt_c);
    end
    srcv = 3'b000;
    #1;
    checks++;
    if (mask_a !== 3'b000 || stall_a !== 1'b0) begin
      errors++;
      $display("FAIL invalid_src: mask=%b stall=%b, expected 000/0", mask_a, stall_a);
    end
    src = '0; srcv = 3'b111; exed = 4'd0; wbe = 1'b1; wbm = 1'b0;
    #1;
    checks++;
    if (mask_a !== 3'b111 || stall_a !== 1'b1) begin
      errors++;
      $display("FAIL reg_zero: mask=%b stall=%b, expected 111/1", mask_a, stall_a);
    end
  endtask

  task automatic test_random();
    logic [NS-1:0] em;
    do_reset();
    fwd = 1'b1;
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < NS; k++) src[k*RW +: RW] = RW'($urandom_range(0, 3));
      srcv  = NS'($urandom);
      wbe   = 1'($urandom_range(0, 1));
      exed  = RW'($urandom_range(0, 3));
      ld    = 1'($urandom_range(0, 1));
      wbm   = 1'($urandom_range(0, 1));
      memd  = RW'($urandom_range(0, 3));
      flush = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 15) == 0) fwd = ~fwd;
      #1;
      em = m_mask(fwd);
      for (int p = 0; p < 3; p++) begin
        checks++;
        if (d_mask[p] !== em || d_stall[p] !== m_stall(p) || d_win[p] !== m_inwin(p) ||
            d_cnt[p] !== 16'(m_cnt[p])) begin
          errors++;
          $display("FAIL random n=%0d inst%0d: mask=%b stall=%b win=%b cnt=%0d, expected %b/%b/%b/%0d",
                   n, p, d_mask[p], d_stall[p], d_win[p], d_cnt[p], em, m_stall(p), m_inwin(p), m_cnt[p]);
        end
      end
      tick();
    end
  endtask

  initial begin
    set_idle();
    reset = 1'b0;
    test_reset();
    test_no_hazard();
    test_nofwd_mem();
    test_fwd_alu();
    test_load_use_lat3();
    test_flush_and_reset();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_stall_controller.md
# hazard_stall_controller

Parametrised successor to the decode-stage hazard detector in the pipeline. It compares up to NUM_SRC decode-stage source registers against the EX and MEM destinations and raises a stall. In forwarding mode it enforces a multi-cycle load-use stall window sized by the memory latency. It also exports a per-source hazard mask and a saturating stall-cycle counter for performance monitoring.

## Interface
Parameters:
- REG_ADDR_W, 4, register-index width
- NUM_SRC, 3, decode source operands checked (1..4)
- MEM_LAT, 1, load-use stall length in cycles (1..7)
- CNT_W, 16, stall statistic counter width

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- i_Src  in  NUM_SRC*REG_ADDR_W  decode source indices; source k at bits [k*REG_ADDR_W +: REG_ADDR_W]
- i_Src_Valid  in  NUM_SRC  per-source used flag (generalises two-source flag)
- i_Sig_Exe_Write_Back_Enable  in  1  EX instruction writes a register
- i_Exe_Destination  in  REG_ADDR_W  EX destination index
- i_Sig_Exe_Memory_Read_Enable  in  1  EX instruction is a load
- i_Sig_Memory_Write_Back_Enable  in  1  MEM instruction writes a register
- i_Memory_Destination  in  REG_ADDR_W  MEM destination index
- i_Sig_Forward_Enable  in  1  forwarding path active
- i_Flush  in  1  branch/exception flush of decode and EX
- o_Sig_Hazard_Detected  out  1  stall decode/fetch and insert a bubble into EX
- o_Hazard_Src  out  NUM_SRC  per-source raw match mask, same-cycle
- o_Stall_Window  out  1  load-use stall window counter non-zero
- o_Stall_Count  out  CNT_W  saturating count of stalled cycles

## Operation
- Per-source match, source k, valid only if i_Src_Valid[k]:
  - exe_hit = i_Sig_Exe_Write_Back_Enable & (src == i_Exe_Destination)
  - mem_hit = i_Sig_Memory_Write_Back_Enable & (src == i_Memory_Destination)
- Forwarding disabled:
  - o_Hazard_Src[k] = exe_hit | mem_hit
  - raw hazard = OR of mask; no window, purely combinational stall
- Forwarding enabled:
  - o_Hazard_Src[k] = exe_hit & i_Sig_Exe_Memory_Read_Enable
  - raw hazard = OR of mask (load-use only)
- Stall window counter, width clog2(MEM_LAT+1):
  - On a cycle with a forwarding-mode raw hazard and counter == 0, load MEM_LAT-1.
  - When non-zero, decrement each cycle.
  - The window ignores raw-hazard re-detection while non-zero.
- o_Sig_Hazard_Detected = (raw hazard | counter != 0) & ~i_Flush
- o_Stall_Window = counter != 0
- i_Flush clears the counter next edge; it has priority over load and decrement.
- o_Stall_Count increments on every cycle o_Sig_Hazard_Detected is 1 and saturates at all-ones. It is never cleared except by reset.
- Register index 0 is an ordinary register; no zero-register exemption.

## Timing
- Detection path combinational: inputs to o_Sig_Hazard_Detected and o_Hazard_Src in the same cycle.
- Load-use with forwarding: stall asserted for exactly MEM_LAT consecutive cycles starting at the detecting cycle. For MEM_LAT=1 this is a single-cycle stall with no counter activity.
- Reset values: counter 0, o_Stall_Count 0, o_Stall_Window 0. o_Sig_Hazard_Detected follows the combinational terms. Reset asserted mid-window aborts the window immediately (asynchronous).
- A toggle of i_Sig_Forward_Enable mid-window does not cancel the window. It ends on count-out or flush.
- Simultaneous flush and new hazard: stall 0 that cycle, counter not loaded.
- Counter saturation: at 2^CNT_W-1 it holds; wrap-around is forbidden.

## Structure
- Package hazard_pkg: default REG_ADDR_W and CNT_W constants, plus a function returning the window counter width from MEM_LAT.
- Sub-module hazard_src_compare (one source against EX/MEM, outputs exe_hit, mem_hit), generated NUM_SRC times.
- Top holds the window counter, statistic counter and output muxing.

## Test plan
- No hazard: sources 3,4,5 valid, EX dest 2, MEM dest 1, forwarding 0 -> stall 0, mask 000, count stays 0.
- No forwarding, MEM match: src1=1, MEM dest 1 with WB enable -> stall 1 same cycle, mask 010, count 1 after edge. Clear WB enable -> stall 0.
- Forwarding, ALU dependency: src0=2, EX dest 2, load 0 -> stall 0. Set load 1 -> stall 1.
- MEM_LAT=3 load-use: single-cycle load hit then EX bubble -> stall high 3 cycles, o_Stall_Window high cycles 2-3, count 3.
- Flush in the 2nd window cycle (MEM_LAT=3) -> stall 0 that cycle, window 0 next cycle, count 1. Then assert reset mid-window -> counter and count 0 immediately.
- CNT_W=4, continuous non-forwarding hazard 20 cycles -> count saturates at 15 and holds. Invalid-source check: i_Src_Valid=0 with matching index -> mask 0.
